// File: rtl/spiflash_fetch_pkg.sv
// Shared opcodes, FSM states and the per-phase shift command for the SPI flash fetch master.
package spiflash_fetch_pkg;

  localparam logic [7:0] OP_PWRUP   = 8'hAB;
  localparam logic [7:0] OP_READ    = 8'h03;
  localparam logic [7:0] OP_QREAD   = 8'hEB;
  localparam logic [7:0] MODE_NOXIP = 8'h00;

  typedef enum logic [3:0] {
    S_PWRUP, S_GAP, S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_DATA, S_HOLD
  } state_e;

  typedef struct packed {
    logic [5:0]  nbits;   // flash_clk periods in this phase
    logic        wide;    // 1: 4 bits per clock, 0: 1 bit per clock
    logic [3:0]  oe;
    logic [31:0] tx;      // MSB-aligned outgoing bits
  } shift_cmd_t;

  // Shift setup for the phase being entered.
  function automatic shift_cmd_t phase_cmd(input state_e st, input logic quad,
                                           input logic [23:0] addr, input logic [5:0] ndummy);
    shift_cmd_t c;
    c = '0;
    case (st)
      S_PWRUP: begin c.nbits = 6'd8; c.oe = 4'b0001; c.tx = {OP_PWRUP, 24'h0}; end
      S_CMD:   begin c.nbits = 6'd8; c.oe = 4'b0001; c.tx = {(quad ? OP_QREAD : OP_READ), 24'h0}; end
      S_ADDR: begin
        c.tx = {addr, 8'h0};
        if (quad) begin c.nbits = 6'd6;  c.wide = 1'b1; c.oe = 4'b1111; end
        else      begin c.nbits = 6'd24; c.oe = 4'b0001; end
      end
      S_MODE:  begin c.nbits = 6'd2; c.wide = 1'b1; c.oe = 4'b1111; c.tx = {MODE_NOXIP, 24'h0}; end
      S_DUMMY: begin c.nbits = ndummy; c.wide = 1'b1; end
      S_DATA:  begin c.nbits = quad ? 6'd8 : 6'd32; c.wide = quad; end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/spiflash_shift_engine.sv
// SPI mode-0 clock divider and shift register: runs one phase of cmd.nbits flash_clk periods.
module spiflash_shift_engine
  import spiflash_fetch_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  shift_cmd_t  cmd,
  input  logic [3:0]  io_di,
  output logic        sclk,
  output logic [3:0]  io_oe,
  output logic [3:0]  io_do,
  output logic [31:0] rx_next,
  output logic        sample_last,
  output logic        done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [5:0]    bit_cnt;
  logic [31:0]   sh;
  logic [30:0]   rx;
  logic          wide_q;
  logic [3:0]    oe_q;
  logic          tick, rise, fall;
  logic [3:0]    bits;

  assign tick        = active && (div_cnt == DIV_LAST);
  assign rise        = tick && !sclk;
  assign fall        = tick && sclk;
  assign sample_last = rise && (bit_cnt == 6'd1);
  assign done        = fall && (bit_cnt == 6'd1);
  assign rx_next     = wide_q ? {rx[27:0], io_di} : {rx[30:0], io_di[1]};

  assign bits  = wide_q ? sh[31:28] : {3'b000, sh[31]};
  assign io_oe = active ? oe_q : 4'h0;
  assign io_do = active ? (bits & oe_q) : 4'h0;

  // A start on the final falling edge chains the next phase with no idle clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sh      <= '0;
      rx      <= '0;
      wide_q  <= 1'b0;
      oe_q    <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      sclk    <= 1'b0;
      bit_cnt <= cmd.nbits;
      sh      <= cmd.tx;
      wide_q  <= cmd.wide;
      oe_q    <= cmd.oe;
    end else if (active) begin
      if (tick) begin
        div_cnt <= '0;
        if (!sclk) begin
          sclk <= 1'b1;
          rx   <= rx_next[30:0];
        end else begin
          sclk    <= 1'b0;
          sh      <= wide_q ? {sh[27:0], 4'h0} : {sh[30:0], 1'b0};
          bit_cnt <= bit_cnt - 6'd1;
          if (bit_cnt == 6'd1) active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spiflash_fetch.sv
// SPI flash read master: 32-bit word fetches via 03/EB reads, keeping CSB low for sequential streams.
module spiflash_fetch
  import spiflash_fetch_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int DUMMY_CYCLES = 8,
  parameter int CSB_IDLE     = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_quad,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic [3:0]  flash_io_oe,
  output logic [3:0]  flash_io_do,
  input  logic [3:0]  flash_io_di
);

  localparam logic [7:0] GAP_LAST = 8'(CSB_IDLE - 1);

  state_e      state_q, state_d;
  logic        csb_q, csb_d;
  logic [23:0] addr_q, ph_addr;
  logic        quad_q, ph_quad;
  logic [7:0]  gap_cnt;
  logic        start, accept, seq_hit;
  shift_cmd_t  cmd;
  logic        eng_done, sample_last;
  logic [31:0] rx_next;

  spiflash_shift_engine #(.CLK_DIV(CLK_DIV)) u_eng (
    .clk         (clk),
    .rst_n       (resetn),
    .start       (start),
    .cmd         (cmd),
    .io_di       (flash_io_di),
    .sclk        (flash_clk),
    .io_oe       (flash_io_oe),
    .io_do       (flash_io_do),
    .rx_next     (rx_next),
    .sample_last (sample_last),
    .done        (eng_done)
  );

  assign seq_hit = (req_addr == addr_q + 24'd4) && (cfg_quad == quad_q);
  // In HOLD a non-sequential request is refused here and taken later from IDLE.
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && (!req_valid || seq_hit));
  assign busy      = !((state_q == S_IDLE) || (state_q == S_HOLD));
  assign flash_csb = csb_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_PWRUP;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    csb_d   = csb_q;
    start   = 1'b0;
    accept  = 1'b0;
    ph_quad = quad_q;
    ph_addr = addr_q;
    case (state_q)
      // csb_q still high means the AB sequence has not been launched yet
      S_PWRUP:
        if (csb_q) begin start = 1'b1; csb_d = 1'b0; end
        else if (eng_done) begin state_d = S_GAP; csb_d = 1'b1; end
      S_GAP:
        if (gap_cnt == GAP_LAST) state_d = S_IDLE;
      S_IDLE:
        if (req_valid) begin
          accept = 1'b1; ph_quad = cfg_quad; ph_addr = req_addr;
          state_d = S_CMD; start = 1'b1; csb_d = 1'b0;
        end
      S_CMD:   if (eng_done) begin state_d = S_ADDR; start = 1'b1; end
      S_ADDR:  if (eng_done) begin state_d = quad_q ? S_MODE : S_DATA; start = 1'b1; end
      S_MODE:  if (eng_done) begin state_d = S_DUMMY; start = 1'b1; end
      S_DUMMY: if (eng_done) begin state_d = S_DATA; start = 1'b1; end
      S_DATA:  if (eng_done) state_d = S_HOLD;
      S_HOLD:
        if (req_valid) begin
          if (seq_hit) begin
            accept = 1'b1; ph_quad = cfg_quad; ph_addr = req_addr;
            state_d = S_DATA; start = 1'b1;
          end else begin
            state_d = S_GAP; csb_d = 1'b1;
          end
        end
      default: state_d = S_PWRUP;
    endcase
    cmd = phase_cmd(state_d, ph_quad, ph_addr, 6'(DUMMY_CYCLES));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csb_q     <= 1'b1;
      addr_q    <= '0;
      quad_q    <= 1'b0;
      gap_cnt   <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      csb_q     <= csb_d;
      gap_cnt   <= (state_q == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
      rsp_valid <= (state_q == S_DATA) && sample_last;
      if (accept) begin
        addr_q <= req_addr;
        quad_q <= cfg_quad;
      end
      // first received byte lands in [7:0]
      if ((state_q == S_DATA) && sample_last)
        rsp_data <= {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    end
  end

endmodule
